// File: rtl/pico_dmem_arbiter_pkg.sv
// pico_dmem_arbiter_pkg: window offsets, STAT/CMD bit indices and FSM encoding shared by the dmem arbiter
package pico_dmem_arbiter_pkg;
   localparam logic [7:0] OFF_ADDR = 8'd0;
   localparam logic [7:0] OFF_DIN  = 8'd1;
   localparam logic [7:0] OFF_CMD  = 8'd2;
   localparam logic [7:0] OFF_STAT = 8'd3;
   localparam logic [7:0] OFF_DOUT = 8'd4;
   localparam logic [7:0] OFF_WAIT = 8'd5;
   localparam int STAT_PEND = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;
   localparam int CMD_WR = 0;
   localparam int CMD_RD = 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GNT_A = 2'd1;
   localparam logic [1:0] S_GNT_B = 2'd2;
endpackage

// File: rtl/pico_dmem_arbiter_if.sv
// pico_dmem_arbiter_if: one PicoBlaze port bus as seen by a peripheral
interface pico_dmem_arbiter_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   modport master (output port_id, out_port, write_strobe, read_strobe, input in_port);
   modport slave  (input port_id, out_port, write_strobe, read_strobe, output in_port);
endinterface

// File: rtl/pico_dmem_arbiter_dmem_req_port.sv
// dmem_req_port: one requester's register window; DMEM_ARB_WAITCNT_EN adds the +5 wait counter
module dmem_req_port
   import pico_dmem_arbiter_pkg::*;
#(
   parameter logic [7:0] BASE = 8'h30,
   parameter int         AW   = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   pico_dmem_arbiter_if.slave bus,
   input  logic              gnt,
`ifdef DMEM_ARB_WAITCNT_EN
   input  logic              other_gnt,
`endif
   input  logic [7:0]        dout,
   output logic [AW-1:0]     addr,
   output logic [7:0]        din,
   output logic              is_wr,
   output logic              pending
);
   logic [7:0] off, stat;
   logic       done, err, wr_hit, rd_stat, cmd_go;
   assign off     = bus.port_id - BASE;
   assign wr_hit  = bus.write_strobe && (off <= OFF_CMD);
   assign rd_stat = bus.read_strobe && (off == OFF_STAT);
   assign cmd_go  = wr_hit && !pending && (off == OFF_CMD) && (bus.out_port[CMD_WR] || bus.out_port[CMD_RD]);
   // window registers; any ADDR/DIN/CMD write while a command is outstanding is dropped and flagged
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr    <= '0;
         din     <= 8'h00;
         is_wr   <= 1'b0;
         pending <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (wr_hit && !pending && off == OFF_ADDR) addr <= bus.out_port[AW-1:0];
         if (wr_hit && !pending && off == OFF_DIN) din <= bus.out_port;
         if (cmd_go) is_wr <= bus.out_port[CMD_WR];
         pending <= cmd_go || (pending && !gnt);
         done    <= gnt || (done && !rd_stat && !cmd_go);
         err     <= (wr_hit && pending) || (err && !rd_stat);
      end
   end
   // status byte assembled from its named bit positions
   always_comb begin
      stat            = 8'h00;
      stat[STAT_PEND] = pending;
      stat[STAT_DONE] = done;
      stat[STAT_ERR]  = err;
   end
`ifdef DMEM_ARB_WAITCNT_EN
   logic [7:0] wait_cnt;
   // cycles spent queued while the other requester holds the memory, saturating at 255
   always_ff @(posedge clk) begin
      if (!reset_n) wait_cnt <= 8'h00;
      else if (bus.read_strobe && off == OFF_WAIT) wait_cnt <= 8'h00;
      else if (pending && other_gnt && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
   end
   assign bus.in_port = off == OFF_STAT ? stat : off == OFF_DOUT ? dout : off == OFF_WAIT ? wait_cnt : 8'h00;
`else
   assign bus.in_port = off == OFF_STAT ? stat : off == OFF_DOUT ? dout : 8'h00;
`endif
endmodule

// File: rtl/pico_dmem_arbiter.sv
// pico_dmem_arbiter: round-robin sharing of one data memory between two picos; DMEM_ARB_WAITCNT_EN enables wait counters
module pico_dmem_arbiter
   import pico_dmem_arbiter_pkg::*;
#(
   parameter int         DEPTH  = 8,
   parameter int         AW     = 3,
   parameter logic [7:0] A_BASE = 8'h30,
   parameter logic [7:0] B_BASE = 8'h40
) (
   input  logic               clk,
   input  logic               reset_n,
   pico_dmem_arbiter_if.slave a,
   pico_dmem_arbiter_if.slave b
);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] a_addr, b_addr;
   logic [7:0]    a_din, b_din, a_dout, b_dout;
   logic          a_wr, b_wr, a_pend, b_pend, gnt_a, gnt_b, rr;
   logic [1:0]    state, nxt;
   assign gnt_a = state == S_GNT_A;
   assign gnt_b = state == S_GNT_B;
   dmem_req_port #(.BASE(A_BASE), .AW(AW)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(a), .gnt(gnt_a),
`ifdef DMEM_ARB_WAITCNT_EN
      .other_gnt(gnt_b),
`endif
      .dout(a_dout), .addr(a_addr), .din(a_din), .is_wr(a_wr), .pending(a_pend)
   );
   dmem_req_port #(.BASE(B_BASE), .AW(AW)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(b), .gnt(gnt_b),
`ifdef DMEM_ARB_WAITCNT_EN
      .other_gnt(gnt_a),
`endif
      .dout(b_dout), .addr(b_addr), .din(b_din), .is_wr(b_wr), .pending(b_pend)
   );
   // rr = 0 favours A, 1 favours B when both are waiting in IDLE
   always_comb begin
      nxt = gnt_a ? (b_pend ? S_GNT_B : S_IDLE) :
            gnt_b ? (a_pend ? S_GNT_A : S_IDLE) :
            (a_pend && (!b_pend || !rr)) ? S_GNT_A :
            b_pend ? S_GNT_B : S_IDLE;
   end
   // the granted requester's access lands on the edge that leaves its GNT state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         rr     <= 1'b0;
         a_dout <= 8'h00;
         b_dout <= 8'h00;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         state <= nxt;
         if (gnt_a) begin
            rr <= 1'b1;
            if (a_wr) mem[a_addr] <= a_din;
            else a_dout <= mem[a_addr];
         end
         if (gnt_b) begin
            rr <= 1'b0;
            if (b_wr) mem[b_addr] <= b_din;
            else b_dout <= mem[b_addr];
         end
      end
   end
endmodule
